// File: rtl/apb_spi_interface.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_interface
// Brief    : APB slave driving a byte serialiser toward four slaves, plus an
//            OOK RF packet receiver built only when RF_RX_EN is defined.
// Revision : 1.0
// ============================================================================
module apb_spi_interface #(
   parameter int BIT_PERIOD   = 10000,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic        i_PCLK,
   input  logic        i_PRESETn,
   input  logic        i_PSEL0,
   input  logic        i_PENABLE,
   input  logic        i_PWRITE,
   input  logic [15:0] i_PADDR,
   input  logic [7:0]  i_PWDATA,
   input  logic [7:0]  i_PRDATA,
   input  logic [9:0]  i_BASE_ADDR,
   output logic        o_WR0,
   output logic        o_WR1,
   output logic        o_WR2,
   output logic        o_WR3,
   output logic        o_DR0,
   output logic        o_DR1,
   output logic        o_DR2,
   output logic        o_DR3,
   output logic        PREADY,
   output logic [7:0]  o_PWDATA,
   output logic [7:0]  o_PRDATA,
   input  logic        rfin,
   output logic        pkt_rec,
   input  logic        RX,
   output logic        TX_OUT,
   output logic        sh_en
);

   localparam logic [5:0] c_off_cfg = 6'h00;
   localparam logic [5:0] c_off_dat = 6'h04;
   localparam logic [5:0] c_off_cmd = 6'h0C;
   localparam logic [0:0] c_xs_idle = 1'b0;
   localparam logic [0:0] c_xs_run  = 1'b1;

   logic       w_hit, w_wr, w_rd, w_busy, w_start, w_tick_end, w_end;
   logic [5:0] w_off;
   logic [3:0] w_div_max, w_sel;
   logic [7:0] w_status;
   logic       w_pkt_take;
   logic [7:0] w_pkt_byte;

   logic [5:0] cfg_q, cfg_d;
   logic [7:0] tx_q, tx_d, rx_q, rx_d, sh_q, sh_d;
   logic       done_q, done_d, rxv_q, rxv_d, dir_q, dir_d;
   logic       txo_q, txo_d, she_q, she_d;
   logic [0:0] xst_q, xst_d;
   logic [1:0] xsl_q, xsl_d, xsck_q, xsck_d;
   logic [3:0] div_cnt_q, div_cnt_d;
   logic [2:0] bit_q, bit_d;

   assign w_hit   = (i_PADDR[15:6] == i_BASE_ADDR);
   assign w_off   = i_PADDR[5:0];
   assign PREADY  = i_PSEL0 & i_PENABLE & w_hit;
   assign w_wr    = PREADY & i_PWRITE;
   assign w_rd    = PREADY & ~i_PWRITE;
   assign w_busy  = (xst_q == c_xs_run);
   assign w_start = w_wr & (w_off == c_off_cmd) & i_PWDATA[1] & ~w_busy;
   assign w_status = {4'b0000, rxv_q, pkt_rec, done_q, w_busy};

   always_comb begin
      case (xsck_q)
         2'd0:    w_div_max = 4'd1;
         2'd1:    w_div_max = 4'd3;
         2'd2:    w_div_max = 4'd7;
         default: w_div_max = 4'd15;
      endcase
   end

   assign w_tick_end = (div_cnt_q == w_div_max);
   assign w_end      = w_busy & w_tick_end & (bit_q == 3'd7);

   // Slave/direction/divider are latched at START so CONFIG writes cannot disturb a transfer.
   always_comb begin
      cfg_d     = cfg_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      done_d    = done_q;
      rxv_d     = rxv_q;
      xst_d     = xst_q;
      dir_d     = dir_q;
      xsl_d     = xsl_q;
      xsck_d    = xsck_q;
      div_cnt_d = div_cnt_q;
      bit_d     = bit_q;
      sh_d      = sh_q;
      txo_d     = txo_q;
      she_d     = 1'b0;
      if (w_wr && w_off == c_off_cfg) cfg_d = i_PWDATA[5:0];
      if (w_wr && w_off == c_off_dat) tx_d = i_PWDATA;
      if (w_rd && w_off == c_off_cfg) done_d = 1'b0;
      if (w_rd && w_off == c_off_dat) rxv_d = 1'b0;
      case (xst_q)
         c_xs_idle: begin
            if (w_start) begin
               xst_d     = c_xs_run;
               dir_d     = RX;
               xsl_d     = cfg_q[3:2];
               xsck_d    = cfg_q[1:0];
               div_cnt_d = 4'd0;
               bit_d     = 3'd0;
               sh_d      = {tx_q[6:0], 1'b0};
               txo_d     = ~RX & tx_q[7];
               she_d     = 1'b1;
            end
         end
         default: begin
            if (!w_tick_end) begin
               div_cnt_d = div_cnt_q + 4'd1;
            end else if (bit_q != 3'd7) begin
               div_cnt_d = 4'd0;
               bit_d     = bit_q + 3'd1;
               txo_d     = ~dir_q & sh_q[7];
               sh_d      = {sh_q[6:0], 1'b0};
               she_d     = 1'b1;
            end else begin
               xst_d  = c_xs_idle;
               txo_d  = 1'b0;
               done_d = 1'b1;
               if (dir_q) begin
                  rxv_d = 1'b1;
                  rx_d  = w_pkt_take ? w_pkt_byte : i_PRDATA;
               end
            end
         end
      endcase
   end

   always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
      if (!i_PRESETn) begin
         cfg_q     <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         done_q    <= 1'b0;
         rxv_q     <= 1'b0;
         xst_q     <= c_xs_idle;
         dir_q     <= 1'b0;
         xsl_q     <= '0;
         xsck_q    <= '0;
         div_cnt_q <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         txo_q     <= 1'b0;
         she_q     <= 1'b0;
      end else begin
         cfg_q     <= cfg_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         done_q    <= done_d;
         rxv_q     <= rxv_d;
         xst_q     <= xst_d;
         dir_q     <= dir_d;
         xsl_q     <= xsl_d;
         xsck_q    <= xsck_d;
         div_cnt_q <= div_cnt_d;
         bit_q     <= bit_d;
         sh_q      <= sh_d;
         txo_q     <= txo_d;
         she_q     <= she_d;
      end
   end

   assign w_sel    = w_busy ? (4'b0001 << xsl_q) : 4'b0000;
   assign o_WR0    = w_sel[0] & ~dir_q;
   assign o_WR1    = w_sel[1] & ~dir_q;
   assign o_WR2    = w_sel[2] & ~dir_q;
   assign o_WR3    = w_sel[3] & ~dir_q;
   assign o_DR0    = w_sel[0] & dir_q;
   assign o_DR1    = w_sel[1] & dir_q;
   assign o_DR2    = w_sel[2] & dir_q;
   assign o_DR3    = w_sel[3] & dir_q;
   assign o_PWDATA = tx_q;
   assign TX_OUT   = txo_q;
   assign sh_en    = she_q;

   always_comb begin
      o_PRDATA = 8'h00;
      if (w_rd) begin
         case (w_off)
            c_off_cfg: o_PRDATA = w_status;
            c_off_dat: o_PRDATA = rx_q;
            default:   o_PRDATA = 8'h00;
         endcase
      end
   end

   logic w_unused_mode;
   assign w_unused_mode = ^cfg_q[5:4];

`ifdef RF_RX_EN
   localparam int c_tw = $clog2((3 * BIT_PERIOD) / 2 + 1);
   localparam int c_pw = $clog2(PREAMBLE_LEN + 1);
   localparam logic [c_tw-1:0] c_half_t = c_tw'(BIT_PERIOD / 2);
   localparam logic [c_tw-1:0] c_late_t = c_tw'((3 * BIT_PERIOD) / 2);
   localparam logic [1:0] c_rf_hunt = 2'd0;
   localparam logic [1:0] c_rf_pre  = 2'd1;
   localparam logic [1:0] c_rf_data = 2'd2;

   logic [2:0]      sync_q;
   logic [1:0]      rfs_q, rfs_d;
   logic [c_tw-1:0] tmr_q, tmr_d;
   logic [c_pw-1:0] pcnt_q, pcnt_d;
   logic [5:0]      dcnt_q, dcnt_d;
   logic [62:0]     dsh_q, dsh_d;
   logic [63:0]     pbuf_q, pbuf_d, w_rot;
   logic [2:0]      rdp_q, rdp_d;
   logic            prec_q, prec_d;
   logic            w_pulse, w_win, w_late;

   assign w_pulse    = sync_q[1] & ~sync_q[2];
   assign w_win      = w_pulse & (tmr_q >= c_half_t) & (tmr_q < c_late_t);
   assign w_late     = (tmr_q >= c_late_t);
   assign w_pkt_take = dir_q & (xsl_q == 2'd3);
   assign w_rot      = pbuf_q << {rdp_q, 3'b000};
   assign w_pkt_byte = w_rot[63:56];
   assign pkt_rec    = prec_q;

   // Packet completion is evaluated after the readout pointer update so it wins a same-cycle race.
   always_comb begin
      rfs_d  = rfs_q;
      tmr_d  = tmr_q;
      pcnt_d = pcnt_q;
      dcnt_d = dcnt_q;
      dsh_d  = dsh_q;
      pbuf_d = pbuf_q;
      rdp_d  = rdp_q;
      prec_d = prec_q;
      if (w_pkt_take && w_end) begin
         rdp_d = rdp_q + 3'd1;
         if (rdp_q == 3'd7) prec_d = 1'b0;
      end
      case (rfs_q)
         c_rf_hunt: begin
            if (w_pulse) begin
               rfs_d  = c_rf_pre;
               tmr_d  = '0;
               pcnt_d = c_pw'(1);
            end
         end
         c_rf_pre: begin
            if (w_win) begin
               tmr_d  = '0;
               pcnt_d = pcnt_q + c_pw'(1);
               if (pcnt_q == c_pw'(PREAMBLE_LEN - 1)) begin
                  rfs_d  = c_rf_data;
                  dcnt_d = 6'd0;
               end
            end else if (w_late) begin
               rfs_d = c_rf_hunt;
            end else begin
               tmr_d = tmr_q + c_tw'(1);
            end
         end
         default: begin
            if (w_win || w_late) begin
               dsh_d  = {dsh_q[61:0], w_win};
               dcnt_d = dcnt_q + 6'd1;
               tmr_d  = w_win ? '0 : c_half_t;
               if (dcnt_q == 6'd63) begin
                  pbuf_d = {dsh_q, w_win};
                  rdp_d  = 3'd0;
                  prec_d = 1'b1;
                  rfs_d  = c_rf_hunt;
               end
            end else begin
               tmr_d = tmr_q + c_tw'(1);
            end
         end
      endcase
   end

   always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
      if (!i_PRESETn) begin
         sync_q <= '0;
         rfs_q  <= c_rf_hunt;
         tmr_q  <= '0;
         pcnt_q <= '0;
         dcnt_q <= '0;
         dsh_q  <= '0;
         pbuf_q <= '0;
         rdp_q  <= '0;
         prec_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], rfin};
         rfs_q  <= rfs_d;
         tmr_q  <= tmr_d;
         pcnt_q <= pcnt_d;
         dcnt_q <= dcnt_d;
         dsh_q  <= dsh_d;
         pbuf_q <= pbuf_d;
         rdp_q  <= rdp_d;
         prec_q <= prec_d;
      end
   end
`else
   localparam int c_unused_rf_cfg = BIT_PERIOD + PREAMBLE_LEN;
   logic w_unused_rf;
   assign w_unused_rf = rfin;
   assign w_pkt_take  = 1'b0;
   assign w_pkt_byte  = 8'h00;
   assign pkt_rec     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_apb_spi_interface.sv
`default_nettype none
// Bench for apb_spi_interface: directed plus random APB/serial traffic and RF packets against a behavioural model.
module tb_apb_spi_interface;
   localparam int P = 40;
`ifdef RF_RX_EN
   localparam bit RF = 1'b1;
`else
   localparam bit RF = 1'b0;
`endif
   localparam logic [9:0] BASE = 10'd1;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0, rfin = 1'b0, rx_dir = 1'b0;
   logic [15:0] paddr = '0;
   logic [7:0]  pwdata = '0, prdata_in = '0;
   logic [9:0]  base_addr = BASE;
   logic        wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, pready, pkt_rec, tx_out, sh_en;
   logic [7:0]  o_pwdata, o_prdata;

   int          total = 0, bad = 0;
   logic [63:0] pkt_model = '0;
   logic        model_prec = 1'b0;
   int          model_ptr = 0;

   always #5 clk = ~clk;

   apb_spi_interface #(.BIT_PERIOD(P), .PREAMBLE_LEN(8)) dut (
      .i_PCLK(clk), .i_PRESETn(rst_n), .i_PSEL0(psel), .i_PENABLE(penable), .i_PWRITE(pwrite),
      .i_PADDR(paddr), .i_PWDATA(pwdata), .i_PRDATA(prdata_in), .i_BASE_ADDR(base_addr),
      .o_WR0(wr0), .o_WR1(wr1), .o_WR2(wr2), .o_WR3(wr3),
      .o_DR0(dr0), .o_DR1(dr1), .o_DR2(dr2), .o_DR3(dr3),
      .PREADY(pready), .o_PWDATA(o_pwdata), .o_PRDATA(o_prdata), .rfin(rfin),
      .pkt_rec(pkt_rec), .RX(rx_dir), .TX_OUT(tx_out), .sh_en(sh_en)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] adr(input logic [5:0] off);
      return {BASE, off};
   endfunction

   task automatic apb_write(input logic [15:0] a, input logic [7:0] dat, output logic rdy);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = dat;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      rdy = pready;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic apb_read(input logic [15:0] a, output logic [7:0] dat, output logic rdy_setup,
                           output logic rdy_acc);
      @(posedge clk); #1;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
      @(negedge clk);
      rdy_setup = pready;
      @(posedge clk); #1;
      penable = 1'b1;
      @(negedge clk);
      dat = o_prdata;
      rdy_acc = pready;
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0;
   endtask

   // One transfer: expected selects, strobe spacing and serial bits come from the byte and divider alone.
   task automatic xfer(input logic is_rx, input logic [1:0] slave, input logic [1:0] sck,
                       input logic [7:0] txb);
      int div, hi, np, wrong;
      logic spacing_ok, r;
      logic [7:0] bits;
      logic [3:0] sel, oth;
      div = 2 << sck; hi = 0; np = 0; wrong = 0; spacing_ok = 1'b1; bits = '0;
      apb_write(adr(6'h00), {2'($urandom), slave, sck}, r);
      if (!is_rx) begin
         apb_write(adr(6'h04), txb, r);
         chk("o_pwdata", o_pwdata, txb);
      end
      rx_dir = is_rx;
      apb_write(adr(6'h0C), 8'h02, r);
      chk("pready_write", r, 1'b1);
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         sel = is_rx ? {dr3, dr2, dr1, dr0} : {wr3, wr2, wr1, wr0};
         oth = is_rx ? {wr3, wr2, wr1, wr0} : {dr3, dr2, dr1, dr0};
         if (sel[slave] !== 1'b1) break;
         hi++;
         if ((sel & ~(4'b0001 << slave)) != 4'b0000 || oth != 4'b0000) wrong++;
         if (sh_en === 1'b1) begin
            if (c != np * div) spacing_ok = 1'b0;
            np++;
            bits = {bits[6:0], tx_out};
         end
      end
      chk("select_cycles", hi, 8 * div);
      chk("select_others", wrong, 0);
      chk("sh_en_count", np, 8);
      chk("sh_en_spacing", spacing_ok, 1'b1);
      chk("tx_bits", bits, is_rx ? 8'h00 : txb);
      chk("tx_out_idle", tx_out, 1'b0);
   endtask

   task automatic rx_readout(input logic [1:0] slave);
      logic [7:0] pd, exp_b, d;
      logic r0, r1;
      pd = 8'($urandom);
      prdata_in = pd;
      xfer(1'b1, slave, 2'd1, 8'h00);
      if (RF && slave == 2'd3) begin
         exp_b = 8'(pkt_model >> (56 - 8 * model_ptr));
         model_ptr = (model_ptr + 1) % 8;
         if (model_ptr == 0) model_prec = 1'b0;
      end else begin
         exp_b = pd;
      end
      apb_read(adr(6'h00), d, r0, r1);
      chk("rx_status", d, {4'b0000, 1'b1, model_prec, 1'b1, 1'b0});
      apb_read(adr(6'h04), d, r0, r1);
      chk("rx_data", d, exp_b);
      chk("pkt_rec_after_read", pkt_rec, model_prec);
   endtask

   // Pulses sit on an ideal grid of P cycles with +/-2 cycles (5%) of jitter; a 0 bit sends nothing.
   task automatic rf_send(input int npre, input logic [63:0] data, input int nbits,
                          output logic prec_before_last);
      int now, target, j, last_k;
      now = 0; last_k = -1; prec_before_last = 1'b0;
      for (int k = 0; k < npre + nbits; k++)
         if (k < npre || data[63 - (k - npre)]) last_k = k;
      for (int k = 0; k < npre + nbits; k++) begin
         if (k < npre || data[63 - (k - npre)]) begin
            j = (k == 0) ? 0 : int'($urandom_range(4)) - 2;
            target = k * P + j;
            while (now < target) begin
               @(posedge clk);
               now++;
            end
            #1;
            if (k == last_k) prec_before_last = pkt_rec;
            rfin = 1'b1;
            repeat (3) begin
               @(posedge clk);
               now++;
            end
            #1 rfin = 1'b0;
         end
      end
   endtask

   task automatic rf_packet(input logic [63:0] pk);
      logic pb;
      logic [7:0] d;
      logic r0, r1;
      rf_send(8, pk, 64, pb);
      chk("pkt_rec_before_last", pb, model_prec);
      for (int c = 0; c < 2 * P && pkt_rec !== 1'b1; c++) @(negedge clk);
      if (RF) begin
         pkt_model = pk;
         model_prec = 1'b1;
         model_ptr = 0;
      end
      chk("pkt_rec_set", pkt_rec, model_prec);
      apb_read(adr(6'h00), d, r0, r1);
      chk("status_pkt", d, {5'b00000, model_prec, 2'b00});
      for (int i = 0; i < 8; i++) rx_readout(2'd3);
      chk("pkt_rec_cleared", pkt_rec, 1'b0);
   endtask

   initial begin
      logic [7:0] d, snap;
      logic r0, r1, pb;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, tx_out, sh_en, pkt_rec, pready,
                            o_pwdata, o_prdata}, '0);
      #1 rst_n = 1'b1;

      apb_read(adr(6'h00), d, r0, r1);
      chk("status_reset", d, 8'h00);
      chk("pready_setup", r0, 1'b0);
      chk("pready_access", r1, 1'b1);

      xfer(1'b0, 2'd3, 2'd1, 8'hA5);
      apb_read(adr(6'h00), d, r0, r1);
      chk("status_done", d, 8'h02);
      apb_read(adr(6'h00), d, r0, r1);
      chk("status_cleared", d, 8'h00);

      for (int i = 0; i < 4; i++) begin
         xfer(1'b0, 2'($urandom), 2'($urandom), 8'($urandom));
         apb_read(adr(6'h00), d, r0, r1);
         chk("status_done_rand", d, 8'h02);
      end

      for (int i = 0; i < 3; i++) rx_readout(2'($urandom_range(2)));
      apb_read(adr(6'h00), d, r0, r1);
      chk("status_after_rx", d, 8'h00);

      rf_packet(64'h8123456789ABCD0F);

      rf_send(4, 64'h0, 0, pb);
      repeat (5 * P / 2) @(posedge clk);
      rf_send(7, 64'h0, 0, pb);
      repeat (3 * P) @(posedge clk);
      @(negedge clk);
      chk("no_pkt_short_preamble", pkt_rec, 1'b0);

      rf_packet({32'($urandom), 32'($urandom)} | 64'h1);

      snap = o_pwdata;
      apb_write({10'd2, 6'h04}, ~snap, r0);
      chk("foreign_pready", r0, 1'b0);
      chk("foreign_tx_unchanged", o_pwdata, snap);
      rx_dir = 1'b0;
      apb_write({10'd2, 6'h0C}, 8'h02, r0);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("foreign_no_xfer", {wr0, wr1, wr2, wr3, dr0, dr1, dr2, dr3, sh_en}, '0);
      end
      apb_read({10'd2, 6'h00}, d, r0, r1);
      chk("foreign_read_pready", r1, 1'b0);
      chk("foreign_read_data", d, 8'h00);
      apb_read(adr(6'h00), d, r0, r1);
      chk("status_final", d, 8'h00);
      apb_read(adr(6'h20), d, r0, r1);
      chk("unmapped_read", d, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
